// File: rtl/gecko_mem_result_tracker_pkg.sv
// Shared types and helpers for the gecko data-memory result tracker.
//   - technology / output-stage mode selectors
//   - gecko_mem_operation_t : load/store command issued by execute
//   - gecko_operation_t     : register result handed to writeback port 1
//   - gecko_mem_tracker_stats_t : optional occupancy/stall statistics
//   - gecko_get_load_operation(): joins a command with its memory data word
package gecko_mem_result_tracker_pkg;

  localparam int unsigned GECKO_MEM_TRACKER_MAX_DEPTH = 64;
  localparam int unsigned GeckoMaxCountWidth = $clog2(GECKO_MEM_TRACKER_MAX_DEPTH + 1);

  typedef enum logic [1:0] {
    STD_TECHNOLOGY_FPGA_XILINX,
    STD_TECHNOLOGY_FPGA_INTEL,
    STD_TECHNOLOGY_GENERIC
  } std_technology_t;

  typedef enum logic {
    STREAM_PIPELINE_MODE_TRANSPARENT,
    STREAM_PIPELINE_MODE_REGISTERED
  } stream_pipeline_mode_t;

  // RV32 load funct3 encodings
  localparam logic [2:0] GeckoLoadLb  = 3'b000;
  localparam logic [2:0] GeckoLoadLh  = 3'b001;
  localparam logic [2:0] GeckoLoadLw  = 3'b010;
  localparam logic [2:0] GeckoLoadLbu = 3'b100;
  localparam logic [2:0] GeckoLoadLhu = 3'b101;

  typedef struct packed {
    logic [4:0] addr;          // destination register
    logic [2:0] op_type;       // load funct3
    logic [1:0] addr_lsb;      // byte offset within the 32-bit word
    logic       mispredicted;
  } gecko_mem_operation_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] value;
    logic        reg_write;
  } gecko_operation_t;

  typedef struct packed {
    logic [31:0]                   stall_cycles;
    logic [GeckoMaxCountWidth-1:0] max_outstanding;
  } gecko_mem_tracker_stats_t;

  // Extract and extend the addressed byte/half/word; mispredicted ops never write back.
  function automatic gecko_operation_t gecko_get_load_operation(gecko_mem_operation_t op,
                                                                logic [31:0] data);
    gecko_operation_t res;
    logic [31:0]      shifted;
    shifted       = data >> {op.addr_lsb, 3'b000};
    res.addr      = op.addr;
    res.reg_write = !op.mispredicted;
    case (op.op_type)
      GeckoLoadLb:  res.value = {{24{shifted[7]}}, shifted[7:0]};
      GeckoLoadLh:  res.value = {{16{shifted[15]}}, shifted[15:0]};
      GeckoLoadLbu: res.value = {24'b0, shifted[7:0]};
      GeckoLoadLhu: res.value = {16'b0, shifted[15:0]};
      default:      res.value = shifted;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gecko_mem_result_tracker_fifo.sv
// gecko_mem_command_fifo: power-of-two circular FIFO of outstanding memory commands.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push_valid_i/ready_o/data_i   enqueue side; ready = count < DEPTH (no full-bypass)
//   pop_i               dequeue the head (ignored when empty)
//   head_valid_o/data_o current head entry
//   count_o             occupancy, 0..DEPTH
module gecko_mem_command_fifo
  import gecko_mem_result_tracker_pkg::*;
#(
  parameter logic            CLOCK_INFO = 1'b0,
  parameter std_technology_t TECHNOLOGY = STD_TECHNOLOGY_FPGA_XILINX,
  parameter int unsigned     DEPTH      = 4,
  localparam int unsigned    CountWidth = $clog2(DEPTH + 1),
  localparam int unsigned    PtrWidth   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  gecko_mem_operation_t  push_data_i,
  input  logic                  pop_i,
  output logic                  head_valid_o,
  output gecko_mem_operation_t  head_data_o,
  output logic [CountWidth-1:0] count_o
);

  if (DEPTH < 2 || DEPTH > GECKO_MEM_TRACKER_MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0)
  begin : gen_bad_depth
    $error("DEPTH must be a power of two in 2..64");
  end

  // Only a single synchronous clock domain is supported.
  if (CLOCK_INFO != 1'b0) begin : gen_bad_clock
    $error("unsupported CLOCK_INFO");
  end

  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  push, pop;

  assign push_ready_o = (count_q < CountWidth'(DEPTH));
  assign head_valid_o = (count_q != '0);
  assign push         = push_valid_i && push_ready_o;
  assign pop          = pop_i && head_valid_o;
  assign count_o      = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap for free because DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  if (TECHNOLOGY == STD_TECHNOLOGY_FPGA_XILINX) begin : gen_lutram
    (* ram_style = "distributed" *) gecko_mem_operation_t mem_q [DEPTH];
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data_i;
    end
    assign head_data_o = mem_q[rd_ptr_q];
  end else begin : gen_regs
    gecko_mem_operation_t mem_q [DEPTH];
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data_i;
    end
    assign head_data_o = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/gecko_mem_result_tracker.sv
// gecko_mem_result_tracker: in-order tracker joining memory commands from execute with
// variable-latency data-memory responses and forwarding the result to writeback port 1.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   mem_command_valid_i/ready_o/data_i    commands from execute
//   data_result_valid_i/ready_o/data_i    in-order responses from data memory
//   memory_result_valid_o/ready_i/data_o  joined result to writeback
//   outstanding_o                   command FIFO occupancy
//   orphan_error_o                  sticky: response with no pending non-mispredicted head
// Optional (GECKO_MEM_RESULT_TRACKER_STATS_EN defined):
//   stall_cycles_o                  saturating count of cycles with command valid && !ready
//   max_outstanding_o               occupancy high-water mark
module gecko_mem_result_tracker
  import gecko_mem_result_tracker_pkg::*;
#(
  parameter logic                  CLOCK_INFO    = 1'b0,
  parameter std_technology_t       TECHNOLOGY    = STD_TECHNOLOGY_FPGA_XILINX,
  parameter int unsigned           DEPTH         = 4,
  parameter stream_pipeline_mode_t PIPELINE_MODE = STREAM_PIPELINE_MODE_TRANSPARENT,
  localparam int unsigned          CountWidth    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_command_valid_i,
  output logic                  mem_command_ready_o,
  input  gecko_mem_operation_t  mem_command_data_i,
  input  logic                  data_result_valid_i,
  output logic                  data_result_ready_o,
  input  logic [31:0]           data_result_data_i,
  output logic                  memory_result_valid_o,
  input  logic                  memory_result_ready_i,
  output gecko_operation_t      memory_result_data_o,
  output logic [CountWidth-1:0] outstanding_o,
  output logic                  orphan_error_o
`ifdef GECKO_MEM_RESULT_TRACKER_STATS_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [CountWidth-1:0] max_outstanding_o
`endif
);

  logic                 head_valid;
  gecko_mem_operation_t head_op;
  logic                 pop;
  logic                 join_valid, join_ready;
  gecko_operation_t     join_data;
  logic                 orphan_q, orphan_d;

  gecko_mem_command_fifo #(
    .CLOCK_INFO (CLOCK_INFO),
    .TECHNOLOGY (TECHNOLOGY),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (mem_command_valid_i),
    .push_ready_o (mem_command_ready_o),
    .push_data_i  (mem_command_data_i),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_data_o  (head_op),
    .count_o      (outstanding_o)
  );

  always_comb begin
    // A mispredicted head retires without waiting for (or consuming) memory data.
    join_valid          = head_valid && (head_op.mispredicted || data_result_valid_i);
    data_result_ready_o = head_valid && !head_op.mispredicted && join_ready;
    join_data           = gecko_get_load_operation(head_op, data_result_data_i);
    pop                 = join_valid && join_ready;
    orphan_d            = orphan_q ||
                          (data_result_valid_i && (!head_valid || head_op.mispredicted));
  end

  always_ff @(posedge clk) begin
    if (rst) orphan_q <= 1'b0;
    else     orphan_q <= orphan_d;
  end

  assign orphan_error_o = orphan_q;

  if (PIPELINE_MODE == STREAM_PIPELINE_MODE_REGISTERED) begin : gen_registered
    logic             out_valid_q, out_valid_d;
    gecko_operation_t out_data_q, out_data_d;

    // Accept whenever the register is empty or draining this cycle: 1 result/cycle.
    assign join_ready = !out_valid_q || memory_result_ready_i;

    always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (join_ready) begin
        out_valid_d = join_valid;
        if (join_valid) out_data_d = join_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) out_valid_q <= 1'b0;
      else     out_valid_q <= out_valid_d;
    end

    always_ff @(posedge clk) begin
      out_data_q <= out_data_d;
    end

    assign memory_result_valid_o = out_valid_q;
    assign memory_result_data_o  = out_data_q;
  end else begin : gen_transparent
    assign join_ready            = memory_result_ready_i;
    assign memory_result_valid_o = join_valid;
    assign memory_result_data_o  = join_data;
  end

`ifdef GECKO_MEM_RESULT_TRACKER_STATS_EN
  gecko_mem_tracker_stats_t stats_q, stats_d;

  always_comb begin
    stats_d = stats_q;
    if (mem_command_valid_i && !mem_command_ready_o && stats_q.stall_cycles != '1) begin
      stats_d.stall_cycles = stats_q.stall_cycles + 32'd1;
    end
    if (GeckoMaxCountWidth'(outstanding_o) > stats_q.max_outstanding) begin
      stats_d.max_outstanding = GeckoMaxCountWidth'(outstanding_o);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stats_q <= '0;
    else     stats_q <= stats_d;
  end

  assign stall_cycles_o    = stats_q.stall_cycles;
  assign max_outstanding_o = stats_q.max_outstanding[CountWidth-1:0];
`endif

endmodule

// File: doc/gecko_mem_result_tracker.md
Name: gecko_mem_result_tracker

Overview:
- Next-generation data-memory result joiner for the gecko core.
- Replaces the fixed-latency command delay line and the combinational load-result merge with a parametrised in-order tracker of DEPTH outstanding load/store commands.
- Tolerates variable data-memory latency, drops responses for mispredicted operations and flags protocol violations.
- Sits between gecko_execute (mem_command) plus the data_result memory port, and writeback port 1.

Parameters:
- CLOCK_INFO, 'b0, clock description passed through to sub-stages.
- TECHNOLOGY, STD_TECHNOLOGY_FPGA_XILINX, target for the FIFO storage.
- DEPTH, 4, maximum outstanding commands; power of two, 2..64.
- PIPELINE_MODE, STREAM_PIPELINE_MODE_TRANSPARENT, mode of the memory_result output stage (TRANSPARENT or REGISTERED).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- mem_command  stream_intf.in  gecko_mem_operation_t  command issued by execute.
- data_result  mem_intf.in  32 data  in-order responses from data memory.
- memory_result  stream_intf.out  gecko_operation_t  joined register result to writeback.
- outstanding  out  $clog2(DEPTH+1)  current command-FIFO occupancy.
- orphan_error  out  1  sticky: response seen with no pending non-mispredicted command.

Behaviour:
- Reset (rst high at a clk edge):
  - Occupancy 0, read/write pointers 0, orphan_error 0.
  - mem_command.ready 1 the cycle after reset deasserts.
  - memory_result.valid 0; data_result.ready 0.
- Push:
  - mem_command.ready = (outstanding < DEPTH). No full-bypass: ready stays 0 when full even if a pop occurs that cycle.
  - Accepted entry becomes head no earlier than the next cycle; minimum latency is 1 cycle from accept to memory_result.valid (TRANSPARENT), 2 cycles (REGISTERED).
- Head join (FIFO not empty):
  - Head mispredicted: result valid immediately, data ignored, data_result.ready 0.
  - Head not mispredicted: result valid = data_result.valid; data_result.ready = result ready.
  - Result payload = gecko_get_load_operation(head, data_result.data).
- Pop:
  - Pop on the memory_result handshake.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- Empty: memory_result.valid 0, data_result.ready 0.
- Orphan detection: data_result.valid while empty, or while head is mispredicted, sets orphan_error; it clears only on rst. The response is not consumed (ready stays 0).
- Reset mid-operation: all pending entries discarded, with no output for them; any memory response arriving afterwards triggers orphan_error.
- REGISTERED mode: output passes through a stream_stage; the join backpressures from the stage's ready. Throughput is 1 result/cycle in both modes.

Optional Feature:
- Macro GECKO_MEM_RESULT_TRACKER_STATS_EN.
- Defined: adds outputs stall_cycles (32b) and max_outstanding ($clog2(DEPTH+1)), both reset to 0.
  - stall_cycles counts cycles with mem_command.valid && !ready, saturating at 2^32-1.
  - max_outstanding is the high-water mark of occupancy.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- gecko_pkg gains:
  - gecko_mem_tracker_stats_t (stall_cycles, max_outstanding).
  - Constant GECKO_MEM_TRACKER_MAX_DEPTH = 64.
  - The existing gecko_get_load_operation is reused.
- One natural sub-module: gecko_mem_command_fifo, a power-of-two circular FIFO with count output and no full-bypass.
- The output stage reuses stream_stage.

Test Plan:
- Single load: push 1 load (rd=5, lw) at cycle 0; response 0xDEADBEEF at cycle 3 -> memory_result at cycle 3 with rd=5, value 0xDEADBEEF; outstanding returns 1->0.
- Fill DEPTH=4: push 5 commands back-to-back with no responses -> ready drops after the 4th; outstanding=4; the 5th is accepted only the cycle after the first pop.
- Mispredicted mix: push load(ok), load(mispredicted), load(ok); respond 0x11, 0x33 -> three results in order; the middle one is emitted without consuming data; data_result.ready never asserted for it.
- Backpressure: memory_result.ready held 0 for 5 cycles with response valid -> data_result.ready 0, no pop, payload stable; release -> single transfer.
- Orphan: data_result.valid with FIFO empty -> orphan_error=1 next cycle, stays 1; rst -> 0.
- Reset mid-op: 3 pending, assert rst 1 cycle -> outstanding=0, memory_result.valid=0; with STATS_EN, stall_cycles and max_outstanding read 0.
